// File: rtl/mod_midi_event_parser.sv
// mod_midi_event_parser
// Turns a decoded MIDI byte stream into complete channel-voice events and
// queues them, together with realtime bytes, in a first-word-fall-through
// event FIFO.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_byte/_valid       decoded MIDI byte and its one-cycle strobe
//   o_evt_valid         FIFO head present
//   i_evt_ready         consumer accepts the head when o_evt_valid is high
//   o_evt_type/chan/d1/d2  head event fields
//   o_fifo_level        entries currently queued (0..FIFO_DEPTH)
//   o_overflow          sticky flag: an event was dropped on a full FIFO
module mod_midi_event_parser #(
  parameter logic [15:0] CHAN_MASK   = 16'hFFFF,
  parameter int          FIFO_DEPTH  = 8,
  parameter bit          VEL0_IS_OFF = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [7:0]                    i_byte,
  input  logic                          i_byte_valid,
  output logic                          o_evt_valid,
  input  logic                          i_evt_ready,
  output logic [2:0]                    o_evt_type,
  output logic [3:0]                    o_evt_chan,
  output logic [6:0]                    o_evt_d1,
  output logic [6:0]                    o_evt_d2,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 21;  // {type[2:0], chan[3:0], d1[6:0], d2[6:0]}
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

  // ---------------------------------------------------------------------
  // Parser
  // ---------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [7:0]      status_q, status_d;
  logic [6:0]      d1_q, d1_d;

  logic            msg_done;
  logic [2:0]      msg_type;
  logic [6:0]      msg_d1;
  logic [6:0]      msg_d2;
  logic            push;
  logic [EW-1:0]   push_evt;

  // The completing byte must reach the FIFO on its own edge, so the event
  // is formed combinationally from the incoming byte and the parser state.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    d1_d     = d1_q;
    msg_done = 1'b0;
    msg_type = '0;
    msg_d1   = d1_q;
    msg_d2   = '0;
    push     = 1'b0;
    push_evt = '0;

    if (i_byte_valid) begin
      if (i_byte >= 8'hF8) begin
        // Realtime: leaves parser state and partial data untouched.
        push     = 1'b1;
        push_evt = {3'd7, 4'd0, i_byte[6:0], 7'd0};
      end else if (i_byte >= 8'hF0) begin
        status_d = '0;
        d1_d     = '0;
        state_d  = (i_byte == 8'hF0) ? SYSEX : IDLE;
      end else if (i_byte[7]) begin
        status_d = i_byte;
        d1_d     = '0;
        state_d  = WAIT_D1;
      end else begin
        case (state_q)
          WAIT_D1: begin
            d1_d = i_byte[6:0];
            // Program change (Cx) and channel aftertouch (Dx) carry one byte.
            if (status_q[6:5] == 2'b10) begin
              msg_done = 1'b1;
              msg_d1   = i_byte[6:0];
            end else begin
              state_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            msg_done = 1'b1;
            msg_d2   = i_byte[6:0];
            state_d  = WAIT_D1;  // running status retained
          end
          default: ;  // IDLE and SYSEX discard data bytes
        endcase
      end
    end

    if (msg_done) begin
      msg_type = status_q[6:4];
      if (VEL0_IS_OFF && msg_type == 3'd1 && msg_d2 == 7'd0) begin
        msg_type = 3'd0;
      end
      push     = CHAN_MASK[status_q[3:0]];
      push_evt = {msg_type, status_q[3:0], msg_d1, msg_d2};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      status_q <= '0;
      d1_q     <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      d1_q     <= d1_d;
    end
  end

  // ---------------------------------------------------------------------
  // Event FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------
  logic [EW-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]  level_q;
  logic           overflow_q;
  logic           pop, full, wr_en;

  assign pop   = (level_q != '0) && i_evt_ready;
  assign full  = (level_q == FULL_LVL);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign wr_en = push && (!full || pop);

  // Storage is cleared on reset so the head fields read zero afterwards.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= push_evt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign o_evt_valid  = (level_q != '0);
  assign {o_evt_type, o_evt_chan, o_evt_d1, o_evt_d2} = mem_q[rd_ptr_q];
  assign o_fifo_level = level_q;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_mod_midi_event_parser.sv
module tb_mod_midi_event_parser;

  localparam int NI = 4;  // 0 default, 1 VEL0_IS_OFF=0, 2 CHAN_MASK=0001, 3 FIFO_DEPTH=4

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] b;
  logic       bv;
  logic       rdy;

  logic       ev_valid [NI];
  logic [2:0] ev_type  [NI];
  logic [3:0] ev_chan  [NI];
  logic [6:0] ev_d1    [NI];
  logic [6:0] ev_d2    [NI];
  logic       ovf      [NI];
  logic [3:0] lvl8     [3];
  logic [2:0] lvl4;

  mod_midi_event_parser u0 (
    .i_clk(clk), .i_rst(rst), .i_byte(b), .i_byte_valid(bv),
    .o_evt_valid(ev_valid[0]), .i_evt_ready(rdy), .o_evt_type(ev_type[0]),
    .o_evt_chan(ev_chan[0]), .o_evt_d1(ev_d1[0]), .o_evt_d2(ev_d2[0]),
    .o_fifo_level(lvl8[0]), .o_overflow(ovf[0]));

  mod_midi_event_parser #(.VEL0_IS_OFF(1'b0)) u1 (
    .i_clk(clk), .i_rst(rst), .i_byte(b), .i_byte_valid(bv),
    .o_evt_valid(ev_valid[1]), .i_evt_ready(rdy), .o_evt_type(ev_type[1]),
    .o_evt_chan(ev_chan[1]), .o_evt_d1(ev_d1[1]), .o_evt_d2(ev_d2[1]),
    .o_fifo_level(lvl8[1]), .o_overflow(ovf[1]));

  mod_midi_event_parser #(.CHAN_MASK(16'h0001)) u2 (
    .i_clk(clk), .i_rst(rst), .i_byte(b), .i_byte_valid(bv),
    .o_evt_valid(ev_valid[2]), .i_evt_ready(rdy), .o_evt_type(ev_type[2]),
    .o_evt_chan(ev_chan[2]), .o_evt_d1(ev_d1[2]), .o_evt_d2(ev_d2[2]),
    .o_fifo_level(lvl8[2]), .o_overflow(ovf[2]));

  mod_midi_event_parser #(.FIFO_DEPTH(4)) u3 (
    .i_clk(clk), .i_rst(rst), .i_byte(b), .i_byte_valid(bv),
    .o_evt_valid(ev_valid[3]), .i_evt_ready(rdy), .o_evt_type(ev_type[3]),
    .o_evt_chan(ev_chan[3]), .o_evt_d1(ev_d1[3]), .o_evt_d2(ev_d2[3]),
    .o_fifo_level(lvl4), .o_overflow(ovf[3]));

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  int          depth_m [NI] = '{8, 8, 8, 4};
  bit          vel0_m  [NI] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [15:0] mask_m  [NI] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFF};
  logic [20:0] exp_q   [NI][$];
  bit          ovf_m   [NI];
  bit          fresh   [NI];
  int          m_status;       // -1: no running status
  logic [6:0]  m_data[$];
  logic [7:0]  seq[$];

  function automatic int lvl_of(input int i);
    if (i == 3) return int'(lvl4);
    return int'(lvl8[i]);
  endfunction

  function automatic logic [31:0] head_of(input int i);
    return 32'({ev_type[i], ev_chan[i], ev_d1[i], ev_d2[i]});
  endfunction

  function automatic logic [31:0] evt(input int ty, input int ch, input int d1, input int d2);
    return 32'({3'(ty), 4'(ch), 7'(d1), 7'(d2)});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      exp_q[i].delete();
      ovf_m[i] = 1'b0;
      fresh[i] = 1'b1;
    end
    m_status = -1;
    m_data.delete();
  endtask

  // Message view: a status byte defines how many data bytes make a message.
  function automatic void model_byte(input logic [7:0] bb, output bit has,
                                     output int ty, output int ch,
                                     output int d1, output int d2);
    int need;
    has = 1'b0; ty = 0; ch = 0; d1 = 0; d2 = 0;
    if (bb >= 8'hF8) begin
      has = 1'b1; ty = 7; d1 = int'(bb) - 128;
    end else if (bb >= 8'h80) begin
      m_status = (bb < 8'hF0) ? int'(bb) : -1;
      m_data.delete();
    end else if (m_status >= 0) begin
      m_data.push_back(bb[6:0]);
      ty   = (m_status / 16) % 8;
      need = (ty == 4 || ty == 5) ? 1 : 2;
      if (m_data.size() == need) begin
        has = 1'b1;
        ch  = m_status % 16;
        d1  = int'(m_data[0]);
        d2  = (need == 2) ? int'(m_data[1]) : 0;
        m_data.delete();
      end
    end
  endfunction

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d valid", i), 32'(ev_valid[i]), 32'(exp_q[i].size() > 0));
      chk($sformatf("u%0d level", i), 32'(lvl_of(i)), 32'(exp_q[i].size()));
      chk($sformatf("u%0d overflow", i), 32'(ovf[i]), 32'(ovf_m[i]));
      if (exp_q[i].size() > 0)
        chk($sformatf("u%0d head", i), head_of(i), 32'(exp_q[i][0]));
      else if (fresh[i])
        chk($sformatf("u%0d head_rst", i), head_of(i), 32'd0);
    end
  endtask

  task automatic step(input logic [7:0] bb, input bit vv, input bit rr);
    bit popm [NI];
    bit has;
    int ty, ch, d1, d2, t;
    b = bb; bv = vv; rdy = rr; rst = 1'b0;
    for (int i = 0; i < NI; i++) popm[i] = rr && (exp_q[i].size() > 0);
    has = 1'b0;
    if (vv) model_byte(bb, has, ty, ch, d1, d2);
    for (int i = 0; i < NI; i++) begin
      if (popm[i]) void'(exp_q[i].pop_front());
      if (has) begin
        t = ty;
        if (t == 1 && d2 == 0 && vel0_m[i]) t = 0;
        if (t == 7 || mask_m[i][ch]) begin
          if (exp_q[i].size() < depth_m[i]) begin
            exp_q[i].push_back(21'(evt(t, ch, d1, d2)));
            fresh[i] = 1'b0;
          end else begin
            ovf_m[i] = 1'b1;
          end
        end
      end
    end
    @(posedge clk); #1;
    check_all();
  endtask

  // Reset is applied with a realtime byte and ready both active to show it wins.
  task automatic do_reset();
    rst = 1'b1; b = 8'hF8; bv = 1'b1; rdy = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0; bv = 1'b0;
    check_all();
  endtask

  task automatic feed(input bit rr);
    foreach (seq[k]) step(seq[k], 1'b1, rr);
  endtask

  // ---------------- directed table for the default instance ----------------
  typedef struct {
    logic [7:0] bb; bit vv; bit rr;
    bit ev; int ty; int ch; int d1; int d2; int lvl;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] bb, input bit vv, input bit rr,
                              input bit ev, input int ty, input int ch,
                              input int d1, input int d2, input int lvl);
    vec_t r;
    r.bb = bb; r.vv = vv; r.rr = rr; r.ev = ev;
    r.ty = ty; r.ch = ch; r.d1 = d1; r.d2 = d2; r.lvl = lvl;
    return r;
  endfunction

  initial begin
    rst = 1'b1; b = '0; bv = 1'b0; rdy = 1'b0;

    tbl.push_back(mk(8'h90, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h3C, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h64, 1, 0, 1, 1, 0, 'h3C, 'h64, 1));
    tbl.push_back(mk(8'h91, 1, 0, 1, 1, 0, 'h3C, 'h64, 1));
    tbl.push_back(mk(8'h40, 1, 0, 1, 1, 0, 'h3C, 'h64, 1));
    tbl.push_back(mk(8'h7F, 1, 0, 1, 1, 0, 'h3C, 'h64, 2));
    tbl.push_back(mk(8'h40, 1, 0, 1, 1, 0, 'h3C, 'h64, 2));
    tbl.push_back(mk(8'h00, 1, 0, 1, 1, 0, 'h3C, 'h64, 3));
    tbl.push_back(mk(8'hB2, 1, 0, 1, 1, 0, 'h3C, 'h64, 3));
    tbl.push_back(mk(8'h07, 1, 0, 1, 1, 0, 'h3C, 'h64, 3));
    tbl.push_back(mk(8'hF8, 1, 0, 1, 1, 0, 'h3C, 'h64, 4));
    tbl.push_back(mk(8'h50, 1, 0, 1, 1, 0, 'h3C, 'h64, 5));
    tbl.push_back(mk(8'hF0, 1, 0, 1, 1, 0, 'h3C, 'h64, 5));
    tbl.push_back(mk(8'h12, 1, 0, 1, 1, 0, 'h3C, 'h64, 5));
    tbl.push_back(mk(8'h34, 1, 0, 1, 1, 0, 'h3C, 'h64, 5));
    tbl.push_back(mk(8'hF7, 1, 0, 1, 1, 0, 'h3C, 'h64, 5));
    tbl.push_back(mk(8'h45, 1, 0, 1, 1, 0, 'h3C, 'h64, 5));
    tbl.push_back(mk(8'hC3, 1, 0, 1, 1, 0, 'h3C, 'h64, 5));
    tbl.push_back(mk(8'h05, 1, 0, 1, 1, 0, 'h3C, 'h64, 6));
    tbl.push_back(mk(8'h00, 0, 1, 1, 1, 1, 'h40, 'h7F, 5));
    tbl.push_back(mk(8'h00, 0, 1, 1, 0, 1, 'h40, 'h00, 4));
    tbl.push_back(mk(8'h00, 0, 1, 1, 7, 0, 'h78, 'h00, 3));
    tbl.push_back(mk(8'h00, 0, 1, 1, 3, 2, 'h07, 'h50, 2));
    tbl.push_back(mk(8'h00, 0, 1, 1, 4, 3, 'h05, 'h00, 1));
    tbl.push_back(mk(8'h00, 0, 1, 0, 0, 0, 0, 0, 0));

    do_reset();
    foreach (tbl[k]) begin
      step(tbl[k].bb, tbl[k].vv, tbl[k].rr);
      chk($sformatf("tbl%0d valid", k), 32'(ev_valid[0]), 32'(tbl[k].ev));
      chk($sformatf("tbl%0d level", k), 32'(lvl_of(0)), 32'(tbl[k].lvl));
      if (tbl[k].ev)
        chk($sformatf("tbl%0d head", k), head_of(0),
            evt(tbl[k].ty, tbl[k].ch, tbl[k].d1, tbl[k].d2));
    end

    // Channel filter and pitch bend.
    do_reset();
    seq = '{8'hE1, 8'h00, 8'h40, 8'hE0, 8'h7F, 8'h3F};
    feed(1'b0);
    chk("mask level", 32'(lvl_of(2)), 32'd1);
    chk("mask head", head_of(2), evt(6, 0, 'h7F, 'h3F));
    chk("nomask level", 32'(lvl_of(0)), 32'd2);
    chk("nomask head", head_of(0), evt(6, 1, 'h00, 'h40));

    // Velocity-zero Note-On with and without remapping.
    do_reset();
    seq = '{8'h91, 8'h40, 8'h7F, 8'h40, 8'h00};
    feed(1'b0);
    step(8'h00, 1'b0, 1'b1);
    chk("vel0 keep", head_of(1), evt(1, 1, 'h40, 'h00));
    chk("vel0 off", head_of(0), evt(0, 1, 'h40, 'h00));

    // Overflow on the 4-deep instance, then push-with-pop while full.
    do_reset();
    seq = '{8'hF8, 8'hF9, 8'hFA, 8'hFB, 8'hFC, 8'hFE};
    feed(1'b0);
    chk("ovf level", 32'(lvl_of(3)), 32'd4);
    chk("ovf flag", 32'(ovf[3]), 32'd1);
    chk("ovf head", head_of(3), evt(7, 0, 'h78, 0));
    step(8'hFF, 1'b1, 1'b1);
    chk("full push+pop level", 32'(lvl_of(3)), 32'd4);
    chk("full push+pop head", head_of(3), evt(7, 0, 'h79, 0));
    step(8'h00, 1'b0, 1'b1);
    chk("ovf head2", head_of(3), evt(7, 0, 'h7A, 0));
    step(8'h00, 1'b0, 1'b1);
    chk("ovf head3", head_of(3), evt(7, 0, 'h7B, 0));
    step(8'h00, 1'b0, 1'b1);
    chk("ovf head4", head_of(3), evt(7, 0, 'h7F, 0));
    chk("ovf sticky", 32'(ovf[3]), 32'd1);
    do_reset();
    chk("rst level", 32'(lvl_of(3)), 32'd0);
    chk("rst ovf", 32'(ovf[3]), 32'd0);
    chk("rst valid", 32'(ev_valid[3]), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      int  sel;
      logic [7:0] rb;
      bit  rv, rr;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        sel = int'($urandom_range(0, 99));
        if (sel < 50)      rb = 8'($urandom_range(8'h00, 8'h7F));
        else if (sel < 75) rb = 8'($urandom_range(8'h80, 8'hEF));
        else if (sel < 85) rb = 8'($urandom_range(8'hF0, 8'hF7));
        else               rb = 8'($urandom_range(8'hF8, 8'hFF));
        rv = ($urandom_range(0, 3) != 0);
        // Alternate between drain-heavy and stall-heavy phases.
        if (((n / 200) % 2) == 0) rr = ($urandom_range(0, 9) < 7);
        else                      rr = ($urandom_range(0, 9) < 2);
        step(rb, rv, rr);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mod_midi_event_parser.md
Name: mod_midi_event_parser

Overview:
Parametrised successor to the single-byte latch path behind the MIDI receiver. It consumes the receiver's decoded byte stream and assembles complete channel-voice messages, tracking running status and SysEx. Realtime bytes are interleaved without disturbing messages in progress. Accepted events are filtered by channel and queued in an event FIFO with a ready/valid output, feeding synth voice logic and the byte display.

Parameters:
CHAN_MASK, 16'hFFFF, bit n=1 enqueues channel n events; masked channels are still parsed, never enqueued
FIFO_DEPTH, 8, event FIFO entries; power of two, >=2
VEL0_IS_OFF, 1, when 1, Note-On with velocity 0 is emitted as NOTE_OFF

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_byte  in  8  decoded MIDI byte
i_byte_valid  in  1  one-cycle strobe; i_byte sampled when high
o_evt_valid  out  1  FIFO head valid
i_evt_ready  in  1  consumer accepts head when o_evt_valid & i_evt_ready
o_evt_type  out  3  0 NOTE_OFF, 1 NOTE_ON, 2 POLY_AT, 3 CC, 4 PROG, 5 CHAN_AT, 6 BEND, 7 REALTIME
o_evt_chan  out  4  channel (0 for REALTIME)
o_evt_d1  out  7  first data byte (note/controller/program/pressure/bend LSB; REALTIME: i_byte[6:0])
o_evt_d2  out  7  second data byte (velocity/value/bend MSB; 0 for 1-byte messages and REALTIME)
o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count
o_overflow  out  1  sticky: an event was dropped on a full FIFO

Behaviour:
- Reset (i_rst high at a clock edge): FIFO empty, o_evt_valid=0, all o_evt_* fields=0, o_fifo_level=0, o_overflow=0, running status cleared, state=IDLE. Reset wins over any same-cycle byte or pop.
- The parser acts only on cycles with i_byte_valid=1.
- Realtime (F8-FF): enqueued immediately as REALTIME. Parser state, running status and partially received data are unchanged.
- Channel status (80-EF): latch status, clear partial data, go to WAIT_D1.
- System common F0-F7: clear running status. F0 goes to SYSEX; F1-F7 go to IDLE. In SYSEX, data bytes are discarded. F7 or any non-realtime status byte leaves SYSEX, and a channel status byte is applied normally.
- Data byte (00-7F):
  - IDLE: discarded.
  - WAIT_D1: store d1. PROG/CHAN_AT complete here; otherwise go to WAIT_D2.
  - WAIT_D2: store d2 and complete.
  - After a message completes, state returns to WAIT_D1 with running status retained.
- Type mapping from status[6:4]: 0 NOTE_OFF, 1 NOTE_ON, 2 POLY_AT, 3 CC, 4 PROG, 5 CHAN_AT, 6 BEND.
  - NOTE_ON with d2=0 and VEL0_IS_OFF=1 maps to NOTE_OFF with d2=0.
- Enqueue condition: completed message with CHAN_MASK[chan]=1, or any REALTIME byte.
- Latency: the event is visible on o_evt_* with o_evt_valid=1 on the cycle after the completing byte's edge when the FIFO was empty (registered output).
- FIFO behaviour:
  - First-word-fall-through; the head is stable while o_evt_valid & ~i_evt_ready.
  - Pop occurs when o_evt_valid & i_evt_ready.
  - Push while full is accepted only if a pop happens in the same cycle; level is then unchanged.
  - Push while full without a pop drops the new event and sets o_overflow, which holds until reset.
  - Simultaneous push and pop on an empty FIFO cannot occur; the push sets the head.
  - Pointers wrap modulo FIFO_DEPTH.
  - o_fifo_level ranges over 0..FIFO_DEPTH.

Test Plan:
- Bytes 90 3C 64 -> one event {NOTE_ON, ch0, 3C, 64}; o_evt_valid high the cycle after byte 64; level=1.
- Running status: 91 40 7F 40 00 -> {NOTE_ON,ch1,40,7F} then {NOTE_OFF,ch1,40,00}. With VEL0_IS_OFF=0, the second event is NOTE_ON.
- Realtime mid-message: B2 07 F8 50 -> {REALTIME,0,78,0} first, then {CC,ch2,07,50}.
- SysEx and orphan data: F0 12 34 F7 45 C3 05 -> only {PROG,ch3,05,0}. Byte 45 is discarded because running status was cleared.
- Filter and pitch bend: CHAN_MASK=16'h0001; E1 00 40 E0 7F 3F -> only {BEND,ch0,7F,3F}.
- Overflow: FIFO_DEPTH=4, i_evt_ready=0, six F8 bytes -> level=4, o_overflow=1, the four head events are intact. Then, with i_evt_ready=1 and an F8 pushed in the same cycle as a pop, level stays at 4. Assert i_rst -> level=0, o_overflow=0, o_evt_valid=0.
